// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// FSM state encoding, buffer entry layout and the control-flow opcodes used by decode.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_pop_s  = pop && (count_r != {CW{1'b0}});
    assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; cleared on reset so the head reads zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, in-order buffering
// of returned words, and redirect handling that discards every stale fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]      state_r;
    logic [0:0]      state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic            req_valid_r;
    logic            req_valid_next_s;
    logic            fault_r;
    logic            fault_next_s;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   discard_next_s;
    logic [CW-1:0]   inflight_s;
    logic [CW-1:0]   occupancy_s;
    logic [CW-1:0]   inflight_next_s;
    logic [CW-1:0]   occupancy_next_s;
    logic [CW:0]     credit_sum_s;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic [XLEN-1:0] pcq_head_s;
    fetch_entry_t    buf_push_s;
    fetch_entry_t    buf_head_s;

    assign accept_s   = req_valid_r && imem_req_ready;
    assign push_s     = imem_resp_valid && !redirect_valid && (discard_r == {CW{1'b0}});
    assign pop_s      = instr_valid && instr_ready;
    assign buf_push_s = {pcq_head_s, imem_resp_data};

    // PC of every accepted request, popped by its response whether kept or dropped
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept_s),
        .push_data (pc_r),
        .pop       (imem_resp_valid),
        .head      (pcq_head_s),
        .count     (inflight_s)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (buf_push_s),
        .pop       (pop_s),
        .head      (buf_head_s),
        .count     (occupancy_s)
    );

    // Next-state evaluation; a redirect overrides every other event in the cycle
    always_comb begin
        inflight_next_s = inflight_s + CW'(accept_s) - CW'(imem_resp_valid);
        if (redirect_valid) begin
            occupancy_next_s = {CW{1'b0}};
            discard_next_s   = inflight_next_s;
            pc_next_s        = redirect_pc;
            if (is_word_aligned(redirect_pc)) begin
                state_next_s = ST_RUN;
                fault_next_s = 1'b0;
            end else begin
                state_next_s = ST_HALT;
                fault_next_s = 1'b1;
            end
        end else begin
            occupancy_next_s = occupancy_s + CW'(push_s) - CW'(pop_s);
            if (imem_resp_valid && (discard_r != {CW{1'b0}})) begin
                discard_next_s = discard_r - CW'(1);
            end else begin
                discard_next_s = discard_r;
            end
            pc_next_s    = accept_s ? (pc_r + 32'd4) : pc_r;
            state_next_s = state_r;
            fault_next_s = fault_r;
        end
        // Request valid is registered from the counts it will be judged against
        credit_sum_s = {1'b0, inflight_next_s} + {1'b0, occupancy_next_s};
        case (state_next_s)
            ST_RUN:  req_valid_next_s = (credit_sum_s < (CW+1)'(DEPTH));
            ST_HALT: req_valid_next_s = 1'b0;
            default: req_valid_next_s = 1'b0;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pc_r        <= RESET_PC;
            req_valid_r <= 1'b0;
            fault_r     <= 1'b0;
            discard_r   <= {CW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            req_valid_r <= req_valid_next_s;
            fault_r     <= fault_next_s;
            discard_r   <= discard_next_s;
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = {pc_r[XLEN-1:2], 2'b00};
    assign instr_valid    = (occupancy_s != {CW{1'b0}});
    assign instr          = buf_head_s.word;
    assign instr_pc       = buf_head_s.pc;
    assign instr_pc_plus4 = buf_head_s.pc + 32'd4;
    assign fetch_fault    = fault_r;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Holds the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words. It presents them, in program order, to the decode control unit as `instr` plus PC metadata. It is the producer end of the `instr` interface that decode consumes. It accepts redirects from execute on taken branches and jumps (`is_branch`/`is_jump` resolution) and drops all stale fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, instruction buffer entries and maximum in-flight requests; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address (bits [1:0] always 0).
- imem_resp_valid  in  1  read data valid; responses are in order, ≥1 cycle after acceptance, never stalled.
- imem_resp_data  in  32  read data.
- instr_valid  out  1  `instr` holds a valid instruction.
- instr_ready  in  1  decode consumes `instr`.
- instr  out  32  instruction word to decode.
- instr_pc  out  32  PC of `instr`.
- instr_pc_plus4  out  32  `instr_pc` + 4, used for JAL/JALR link (result_src = 2).
- redirect_valid  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  32  new fetch target.
- fetch_fault  out  1  sticky misaligned-target flag.

## Operation
- State machine: RUN, HALT.
- RUN:
  - imem_req_valid = 1 when inflight + occupancy < DEPTH, using registered counts only (no same-cycle credit).
  - imem_req_addr = pc.
  - On handshake: pc += 4 (mod 2^32, wraps silently); pc is pushed to the in-flight PC queue; inflight++.
- Response:
  - inflight--.
  - If discard_cnt > 0: discard_cnt--, data dropped.
  - Else: {pc from in-flight queue, data} pushed to the buffer.
- Pop: instr_valid = buffer non-empty; pop when instr_valid && instr_ready. Outputs come from the buffer head.
- Redirect has priority over every other event in the same cycle:
  - Buffer flushed.
  - discard_cnt = inflight after the current cycle's accept/response updates. A request accepted in the redirect cycle carries the old address and counts as stale. A response arriving in the redirect cycle is dropped.
  - pc = redirect_pc.
  - If redirect_pc[1:0] ≠ 0: fetch_fault = 1, go to HALT. Otherwise go to RUN.
- HALT:
  - imem_req_valid = 0.
  - Outstanding responses are still counted and dropped.
  - A later aligned redirect clears fetch_fault and returns to RUN.
- Pop and push in the same cycle are legal at any occupancy. Pushing to a full buffer cannot occur, because the credit rule prevents it.

## Timing
- Reset values:
  - pc = RESET_PC; state RUN.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - instr_valid = 0, instr = 0, instr_pc = 0, instr_pc_plus4 = 4.
  - fetch_fault = 0; inflight, occupancy and discard_cnt = 0.
- First request is asserted in the first cycle after rst deasserts.
- Response in cycle N → instr_valid in cycle N+1 (buffer is registered, no bypass).
- Redirect in cycle N → first request at redirect_pc in cycle N+1. instr_valid is 0 from cycle N+1 until that fetch returns.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests must not arrive after reset; the memory is reset by the same rst.
- Steady state with 1-cycle memory and instr_ready = 1: one instruction per cycle for DEPTH ≥ 3.

## Structure
- Shared package:
  - XLEN = 32.
  - Reset PC default.
  - State encoding (RUN, HALT).
  - Opcode constants already used by decode (JAL, JALR, BRANCH) for bench checking.
- Sub-module `sync_fifo`, parameterised width/depth with push/pop/flush/count. Two instances:
  - in-flight PC queue (32 b);
  - instruction buffer (64 b: {pc, instr}).
- Counters are $clog2(DEPTH)+1 bits wide.

## Test plan
- Reset, memory always ready, 1-cycle latency, instr_ready = 1 → requests at 0x0, 0x4, 0x8…; instr_pc tracks them; instr_pc_plus4 = instr_pc + 4; after fill, one instr per cycle.
- instr_ready = 0 → exactly DEPTH (4) requests issued, then imem_req_valid = 0 until a pop; no instruction lost or duplicated.
- Redirect to 0x100 with 3 requests in flight → 3 responses dropped; next instr_pc = 0x100; no instr_valid in between.
- Redirect coincident with request accept and response → both stale; first delivered instr_pc = redirect target.
- redirect_pc = 0x102 → fetch_fault = 1, no requests issued; then redirect 0x200 → fault cleared, fetch resumes at 0x200.
- pc = 0xFFFF_FFFC → next request 0x0000_0000; async rst pulse mid-stream → all outputs at reset values in the same cycle.
